heap_request_sequencer: RTL

// - Upstream driver for the heap Memory block: takes one array request per valid/ready handshake and presents it on the heap port.
// - Produces exactly one heap_clock transition per request, waits a fixed settle time, then captures heap_out/heap_error.
// - Returns the result on a valid/ready response channel. Sits between the fpga program sequencer and the heap.

---
 rtl/heap_request_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/heap_request_sequencer.sv
// Sequences one heap operation per accepted request: drive operands, toggle heap_clock once, settle, capture, respond.
// Optional HEAP_SEQ_STICKY_ERR_EN: the first consumed error response latches and answers every later request until reset.
module heap_request_sequencer #(
    parameter int ADDRESS_BITS  = 2,
    parameter int INDEX_BITS    = 1,
    parameter int DATA_BITS     = 12,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_ACTION    = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [DATA_BITS-1:0]    req_in,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BITS-1:0]    rsp_out,
    output logic [31:0]             rsp_error,
    output logic                    heap_clock,
    output logic [7:0]              heap_action,
    output logic [ADDRESS_BITS-1:0] heap_array,
    output logic [INDEX_BITS-1:0]   heap_index,
    output logic [DATA_BITS-1:0]    heap_in,
    input  logic [DATA_BITS-1:0]    heap_out,
    input  logic [31:0]             heap_error,
    output logic [31:0]             ops_done
);

    localparam int          CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]  MAX_ACT     = 8'(MAX_ACTION);
    localparam logic [31:0] ILLEGAL_ERR = 32'h1000_0280;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_STROBE,
        S_SETTLE,
        S_RESPOND
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              act_q, act_d;
    logic [ADDRESS_BITS-1:0] arr_q, arr_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [DATA_BITS-1:0]    din_q, din_d;
    logic                    hclk_q, hclk_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0]    rsp_out_q, rsp_out_d;
    logic [31:0]             rsp_err_q, rsp_err_d;
    logic [31:0]             ops_q, ops_d;
    logic                    legal;

`ifdef HEAP_SEQ_STICKY_ERR_EN
    logic sticky_q, sticky_d;

    always_ff @(posedge clock) begin
        if (reset) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end
`else
    logic sticky_q;
    assign sticky_q = 1'b0;
`endif

    assign legal = (req_action != 8'h00) && (req_action <= MAX_ACT);

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        arr_d     = arr_q;
        idx_d     = idx_q;
        din_d     = din_q;
        hclk_d    = hclk_q;
        cnt_d     = cnt_q;
        rsp_out_d = rsp_out_q;
        rsp_err_d = rsp_err_q;
        ops_d     = ops_q;
`ifdef HEAP_SEQ_STICKY_ERR_EN
        sticky_d  = sticky_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    // Latched error wins over everything; rsp_error already holds it.
                    if (sticky_q) begin
                        rsp_out_d = '0;
                        state_d   = S_RESPOND;
                    end else if (legal) begin
                        act_d   = req_action;
                        arr_d   = req_array;
                        idx_d   = req_index;
                        din_d   = req_in;
                        state_d = S_DRIVE;
                    end else begin
                        rsp_out_d = '0;
                        rsp_err_d = ILLEGAL_ERR;
                        state_d   = S_RESPOND;
                    end
                end
            end
            S_DRIVE: begin
                hclk_d  = ~hclk_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_out_d = heap_out;
                    rsp_err_d = heap_error;
                    state_d   = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    ops_d   = ops_q + 32'd1;
                    state_d = S_IDLE;
`ifdef HEAP_SEQ_STICKY_ERR_EN
                    if (rsp_err_q != 32'h0) sticky_d = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            act_q     <= 8'h00;
            arr_q     <= '0;
            idx_q     <= '0;
            din_q     <= '0;
            hclk_q    <= 1'b0;
            cnt_q     <= '0;
            rsp_out_q <= '0;
            rsp_err_q <= 32'h0;
            ops_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            arr_q     <= arr_d;
            idx_q     <= idx_d;
            din_q     <= din_d;
            hclk_q    <= hclk_d;
            cnt_q     <= cnt_d;
            rsp_out_q <= rsp_out_d;
            rsp_err_q <= rsp_err_d;
            ops_q     <= ops_d;
        end
    end

    // The heap sees a real action only while an operation is in flight.
    assign heap_action = (state_q == S_DRIVE || state_q == S_STROBE || state_q == S_SETTLE) ? act_q : 8'h00;
    assign heap_array  = arr_q;
    assign heap_index  = idx_q;
    assign heap_in     = din_q;
    assign heap_clock  = hclk_q;
    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESPOND);
    assign rsp_out     = rsp_out_q;
    assign rsp_error   = rsp_err_q;
    assign ops_done    = ops_q;

endmodule
